// File: rtl/uart_pkg.sv
// Shared constants, state encodings and helpers for the UART channel.
// Frame is 8N1 by default; defining UART_PARITY_EN selects 8E1.
package uart_pkg;

    localparam int          OVS        = 16;
    localparam int          FIFO_DEPTH = 16;
    localparam logic [15:0] RST_DIV    = 16'd26;

    localparam logic [3:0]  OVS_LAST   = 4'(OVS - 1);
    localparam logic [3:0]  OVS_MID    = 4'(OVS / 2 - 1);

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
`ifdef UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP  = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
`ifdef UART_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP  = 3'd4
    } rx_state_t;

    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead synchronous FIFO with exact occupancy count; DEPTH must be a power of two.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     ren,
    output logic [DATA_W-1:0]        rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   usedw
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    assign empty = (usedw == '0);
    assign full  = (usedw == CNT_FULL);
    assign wr_ok = wen && !full;
    assign rd_ok = ren && !empty;
    // Head reads as zero while empty so the output is defined without resetting storage.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_ok, rd_ok})
                2'b10:   usedw <= usedw + CNT_ONE;
                2'b01:   usedw <= usedw - CNT_ONE;
                default: usedw <= usedw;
            endcase
        end
    end

endmodule

// File: rtl/uart_chan.sv
// UART channel: baud divider, TX/RX state machines and two 16-deep FIFOs.
// Define UART_PARITY_EN for an 8E1 frame; otherwise the frame is 8N1.
module uart_chan
    import uart_pkg::*;
#(
    parameter logic [15:0] RST_BAUD = RST_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        latch_baud,
    input  logic [15:0] baud_word,
    input  logic        self_loop,
    input  logic        tx_fifo_wen,
    input  logic [7:0]  tx_fifo_wdata,
    output logic        tx_fifo_empty,
    output logic        tx_fifo_full,
    output logic [4:0]  tx_fifo_usedw,
    input  logic        rx_fifo_ren,
    output logic [7:0]  rx_fifo_rdata,
    output logic        rx_fifo_empty,
    output logic        rx_fifo_full,
    output logic [4:0]  rx_fifo_usedw,
    output logic        tx_work,
    output logic        rx_overflow,
    output logic        rx_parity_err,
    output logic        txd,
    input  logic        rxd
);

    logic [15:0] baud_reg;
    logic [15:0] div_cnt;
    logic        tick;

    tx_state_t   tx_state;
    logic [3:0]  tx_tick_cnt;
    logic [2:0]  tx_bit_cnt;
    logic [2:0]  tx_bit_nxt;
    logic [7:0]  tx_byte;
    logic [7:0]  tx_rdata;
    logic        tx_line;
    logic        tx_bit_end;
    logic        tx_pop;

    rx_state_t   rx_state;
    logic [3:0]  rx_tick_cnt;
    logic [2:0]  rx_bit_cnt;
    logic [7:0]  rx_byte;
    logic        rx_src;
    logic        rxd_p0;
    logic        rxd_p1;
    logic        rx_in;
    logic        rx_idle_seen;
    logic        rx_bit_end;
    logic        rx_push;
`ifdef UART_PARITY_EN
    logic        rx_par_bad;
`endif

    // Baud tick: one pulse every baud_reg+1 clocks, restarted by latch_baud.
    assign tick = (div_cnt == baud_reg) && !latch_baud;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_reg <= RST_BAUD;
            div_cnt  <= '0;
        end else if (latch_baud) begin
            baud_reg <= baud_word;
            div_cnt  <= '0;
        end else if (tick) begin
            div_cnt  <= '0;
        end else begin
            div_cnt  <= div_cnt + 16'd1;
        end
    end

    uart_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wen   (tx_fifo_wen),
        .wdata (tx_fifo_wdata),
        .ren   (tx_pop),
        .rdata (tx_rdata),
        .empty (tx_fifo_empty),
        .full  (tx_fifo_full),
        .usedw (tx_fifo_usedw)
    );

    uart_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .wen   (rx_push),
        .wdata (rx_byte),
        .ren   (rx_fifo_ren),
        .rdata (rx_fifo_rdata),
        .empty (rx_fifo_empty),
        .full  (rx_fifo_full),
        .usedw (rx_fifo_usedw)
    );

    // ---------------- transmitter ----------------
    assign tx_bit_end = tick && (tx_tick_cnt == OVS_LAST);
    assign tx_bit_nxt = tx_bit_cnt + 3'd1;
    assign tx_pop     = !tx_fifo_empty &&
                        ((tx_state == TX_IDLE && tick) || (tx_state == TX_STOP && tx_bit_end));
    assign txd        = self_loop ? 1'b1 : tx_line;

    always_ff @(posedge clk) begin
        if (tx_pop)
            tx_byte <= tx_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state    <= TX_IDLE;
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_line     <= 1'b1;
            tx_work     <= 1'b0;
        end else begin
            // The 4-bit tick counter wraps by itself at each bit boundary.
            if (tick && tx_state != TX_IDLE)
                tx_tick_cnt <= tx_tick_cnt + 4'd1;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_state    <= TX_START;
                        tx_tick_cnt <= '0;
                        tx_line     <= 1'b0;
                        tx_work     <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_state   <= TX_DATA;
                        tx_bit_cnt <= '0;
                        tx_line    <= tx_byte[0];
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx_state <= TX_PARITY;
                            tx_line  <= even_par(tx_byte);
`else
                            tx_state <= TX_STOP;
                            tx_line  <= 1'b1;
`endif
                        end else begin
                            tx_bit_cnt <= tx_bit_nxt;
                            tx_line    <= tx_byte[tx_bit_nxt];
                        end
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_STOP;
                        tx_line  <= 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    if (tx_bit_end) begin
                        if (tx_pop) begin
                            tx_state <= TX_START;
                            tx_line  <= 1'b0;
                        end else begin
                            tx_state <= TX_IDLE;
                            tx_work  <= 1'b0;
                        end
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_line  <= 1'b1;
                    tx_work  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    assign rx_src      = self_loop ? tx_line : rxd;
    assign rx_in       = rxd_p1;
    assign rx_bit_end  = tick && (rx_tick_cnt == OVS_LAST);
    assign rx_overflow = rx_push && rx_fifo_full;

    // Synchronizer resets low so the line must be seen high before any start is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_p0 <= 1'b0;
            rxd_p1 <= 1'b0;
        end else begin
            rxd_p0 <= rx_src;
            rxd_p1 <= rxd_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == RX_DATA && rx_bit_end)
            rx_byte <= {rx_in, rx_byte[7:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state     <= RX_IDLE;
            rx_tick_cnt  <= '0;
            rx_bit_cnt   <= '0;
            rx_idle_seen <= 1'b0;
            rx_push      <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad    <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_push <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            if (rx_in)
                rx_idle_seen <= 1'b1;
            if (tick && rx_state != RX_IDLE)
                rx_tick_cnt <= rx_tick_cnt + 4'd1;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_idle_seen && !rx_in) begin
                        rx_state    <= RX_START;
                        rx_tick_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (tick && rx_tick_cnt == OVS_MID) begin
                        rx_tick_cnt <= '0;
                        if (!rx_in) begin
                            rx_state   <= RX_DATA;
                            rx_bit_cnt <= '0;
                        end else begin
                            rx_state   <= RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        if (rx_bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        end else begin
                            rx_bit_cnt <= rx_bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (rx_bit_end) begin
                        rx_par_bad <= (rx_in != even_par(rx_byte));
                        rx_state   <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_state <= RX_IDLE;
                        // A low stop bit also forces a fresh idle before the next start.
                        if (!rx_in)
                            rx_idle_seen <= 1'b0;
`ifdef UART_PARITY_EN
                        else if (rx_par_bad)
                            rx_parity_err <= 1'b1;
`endif
                        else
                            rx_push <= 1'b1;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

`ifndef UART_PARITY_EN
    assign rx_parity_err = 1'b0;
`endif

endmodule
